// File: rtl/pad_pkg.sv
// pad_pkg: shared matrix geometry, polarity constants and pad index mapping
package pad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_PADS = 16;
  localparam logic ROW_ACTIVE = 1'b0;
  localparam logic COL_PRESSED = 1'b0;
  function automatic int padIndex(input int row, input int col);
    return row * NUM_COLS + col;
  endfunction
endpackage

// File: rtl/pad_debounce.sv
// pad_debounce: one-bit counting debouncer with registered press pulse
module pad_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sampleEn,
  input  logic raw,
  output logic stable,
  output logic pressPulse
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [CW-1:0] cnt;
  logic prev;
  logic differ;
  logic flip;
  assign differ = raw != stable;
  assign flip = sampleEn && differ && cnt == CW'(DEBOUNCE - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      stable <= 1'b0;
      cnt <= '0;
      prev <= 1'b0;
      pressPulse <= 1'b0;
    end else begin
      prev <= stable;
      pressPulse <= stable && !prev;
      if (sampleEn) cnt <= differ && !flip ? cnt + 1'b1 : '0;
      if (flip) stable <= !stable;
    end
  end
endmodule

// File: rtl/pad_scanner.sv
// pad_scanner: 4x4 pad matrix and mode button scanner with per-key debounce
module pad_scanner
  import pad_pkg::*;
#(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] colIn,
  input  logic                modeIn,
  output logic [NUM_ROWS-1:0] rowDrive,
  output logic [NUM_PADS-1:0] data,
  output logic [NUM_PADS-1:0] padState,
  output logic                modePulse
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [NUM_COLS-1:0] col_s1, col_s2;
  logic mode_s1, mode_s2;
  logic [DW-1:0] div_cnt;
  logic [1:0] row_idx;
  logic tick;
  assign tick = div_cnt == DW'(SCAN_DIV - 1);
  assign rowDrive = ~({NUM_ROWS{ROW_ACTIVE}} ^ (NUM_ROWS'(1) << row_idx));
  // synchronizers hold the pressed sense (1 = pressed), so reset means released
  always_ff @(posedge clock) begin
    if (reset) begin
      col_s1 <= '0;
      col_s2 <= '0;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      div_cnt <= '0;
      row_idx <= '0;
    end else begin
      col_s1 <= ~(colIn ^ {NUM_COLS{COL_PRESSED}});
      col_s2 <= col_s1;
      mode_s1 <= modeIn == COL_PRESSED;
      mode_s2 <= mode_s1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) row_idx <= row_idx + 1'b1;
    end
  end
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      pad_debounce #(.DEBOUNCE(DEBOUNCE)) u_pad (
        .clock(clock),
        .reset(reset),
        .sampleEn(tick && row_idx == 2'(r)),
        .raw(col_s2[c]),
        .stable(padState[padIndex(r, c)]),
        .pressPulse(data[padIndex(r, c)])
      );
    end
  end
  pad_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode (
    .clock(clock),
    .reset(reset),
    .sampleEn(tick),
    .raw(mode_s2),
    .stable(),
    .pressPulse(modePulse)
  );
endmodule

// File: tb/tb_pad_scanner.sv
// tb_pad_scanner: directed scoreboard bench for pad_scanner (SCAN_DIV=4, DEBOUNCE=3)
module tb_pad_scanner;
  logic clock = 1'b0;
  logic reset;
  logic [3:0] colIn;
  logic modeIn;
  logic [3:0] rowDrive;
  logic [15:0] data;
  logic [15:0] padState;
  logic modePulse;
  logic [15:0] pads;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int at; logic [15:0] d; logic m;} exp_t;
  exp_t sb[$];

  pad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clock(clock), .reset(reset), .colIn(colIn), .modeIn(modeIn),
    .rowDrive(rowDrive), .data(data), .padState(padState), .modePulse(modePulse)
  );

  always #5 clock = ~clock;

  // cycles since the last reset release, matching the divider phase
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  // passive matrix: a pressed pad pulls its column low while its row is driven
  always_comb begin
    colIn = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!rowDrive[r]) colIn = colIn & ~pads[r*4 +: 4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  function automatic void push(input int at, input logic [15:0] d, input logic m);
    exp_t e;
    e.at = at;
    e.d = d;
    e.m = m;
    sb.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (!reset && (data != 16'h0 || modePulse)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {15'h0, modePulse, data}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_data", {16'h0, data}, {16'h0, e.d});
        check("pulse_mode", {31'h0, modePulse}, {31'h0, e.m});
        check("pulse_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    pads = '0;
    modeIn = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_rowDrive", {28'h0, rowDrive}, 32'he);
    check("reset_data", {16'h0, data}, 32'h0);
    check("reset_padState", {16'h0, padState}, 32'h0);
    check("reset_modePulse", {31'h0, modePulse}, 32'h0);
    reset = 1'b0;
    wait_cyc(4);  check("row_step1", {28'h0, rowDrive}, 32'hd);
    wait_cyc(8);  check("row_step2", {28'h0, rowDrive}, 32'hb);
    wait_cyc(12); check("row_step3", {28'h0, rowDrive}, 32'h7);
    wait_cyc(16); check("row_wrap", {28'h0, rowDrive}, 32'he);
    pads[5] = 1'b1;
    push(57, 16'h0020, 1'b0);
    wait_cyc(55);  check("pad5_before", {16'h0, padState}, 32'h0);
    wait_cyc(56);  check("pad5_rise", {16'h0, padState}, 32'h0020);
    wait_cyc(80);  pads[5] = 1'b0;
    wait_cyc(119); check("pad5_held", {16'h0, padState}, 32'h0020);
    wait_cyc(120); check("pad5_fall", {16'h0, padState}, 32'h0);
    wait_cyc(128); pads[5] = 1'b1;
    push(217, 16'h0020, 1'b0);
    wait_cyc(156); pads[5] = 1'b0;
    wait_cyc(172); pads[5] = 1'b1;
    wait_cyc(215); check("bounce_not_yet", {16'h0, padState}, 32'h0);
    wait_cyc(220); pads[5] = 1'b0;
    wait_cyc(272); pads[8] = 1'b1; pads[11] = 1'b1;
    push(317, 16'h0900, 1'b0);
    wait_cyc(320); pads = '0;
    wait_cyc(368); pads[0] = 1'b1; pads[15] = 1'b1;
    push(405, 16'h0001, 1'b0);
    push(417, 16'h8000, 1'b0);
    wait_cyc(420); pads = '0;
    wait_cyc(470); check("all_released", {16'h0, padState}, 32'h0);
    wait_cyc(472); modeIn = 1'b0;
    push(485, 16'h0, 1'b1);
    wait_cyc(484); modeIn = 1'b1;
    wait_cyc(500); modeIn = 1'b0;
    wait_cyc(508); modeIn = 1'b1;
    wait_cyc(528); pads[3] = 1'b1;
    wait_cyc(556); check("pad3_before_reset", {16'h0, padState}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("pad3_in_reset", {16'h0, padState}, 32'h0);
    check("row_in_reset", {28'h0, rowDrive}, 32'he);
    reset = 1'b0;
    push(37, 16'h0008, 1'b0);
    wait_cyc(35); check("pad3_fresh_wait", {16'h0, padState}, 32'h0);
    wait_cyc(36); check("pad3_rise", {16'h0, padState}, 32'h0008);
    wait_cyc(45); pads = '0;
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
